// File: rtl/eth_tx_sched.sv
// GMII TX frame scheduler: one start pulse per frame, ARP/UDP alternation, inter-frame gap, watchdog.
// Start pulse follows an accepted arp_req by 2 cycles. There is no backpressure; ARP requests beyond the single slot are dropped.
module eth_tx_sched #(
    parameter int IFG_CYCLES = 12,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_W      = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             arp_req,
    input  logic             arp_req_oper,
    input  logic             udp_frame_ready,
    input  logic             tx_frame_done,
    output logic             eth_header_arp_tx_start,
    output logic             eth_header_ip_tx_start,
    output logic             arp_oper,
    output logic             busy,
    output logic             arp_drop,
    output logic             tx_timeout,
    output logic [CNT_W-1:0] arp_frame_cnt,
    output logic [CNT_W-1:0] udp_frame_cnt
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int IW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_IFG
    } state_t;

    state_t           state_q, state_d;
    // The granted side doubles as last_grant: it is only rewritten on the next grant.
    logic             grant_arp_q, grant_arp_d;
    logic             pending_q, pending_d;
    logic             oper_q, oper_d;
    logic             drop_q, drop_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [IW-1:0]    ifg_q, ifg_d;
    logic [CNT_W-1:0] arp_cnt_q, arp_cnt_d;
    logic [CNT_W-1:0] udp_cnt_q, udp_cnt_d;
    logic             timeout_hit;
    logic             slot_clr;
    logic             accept;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= S_IDLE;
            grant_arp_q <= 1'b0;
            pending_q   <= 1'b0;
            oper_q      <= 1'b0;
            drop_q      <= 1'b0;
            timer_q     <= '0;
            ifg_q       <= '0;
            arp_cnt_q   <= '0;
            udp_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_arp_q <= grant_arp_d;
            pending_q   <= pending_d;
            oper_q      <= oper_d;
            drop_q      <= drop_d;
            timer_q     <= timer_d;
            ifg_q       <= ifg_d;
            arp_cnt_q   <= arp_cnt_d;
            udp_cnt_q   <= udp_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_arp_d = grant_arp_q;
        timer_d     = timer_q;
        ifg_d       = ifg_q;
        arp_cnt_d   = arp_cnt_q;
        udp_cnt_d   = udp_cnt_q;
        timeout_hit = 1'b0;
        slot_clr    = 1'b0;
        accept      = 1'b0;
        pending_d   = pending_q;
        oper_d      = oper_q;
        drop_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pending_q || udp_frame_ready) begin
                    // With both sides waiting, hand the slot to the side not served last.
                    grant_arp_d = pending_q && (!udp_frame_ready || !grant_arp_q);
                    state_d     = S_START;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (tx_frame_done) begin
                    if (grant_arp_q) begin
                        arp_cnt_d = arp_cnt_q + 1'b1;
                    end else begin
                        udp_cnt_d = udp_cnt_q + 1'b1;
                    end
                    slot_clr = grant_arp_q;
                    ifg_d    = '0;
                    state_d  = S_IFG;
                end else if (timer_q == T_LAST) begin
                    timeout_hit = 1'b1;
                    slot_clr    = grant_arp_q;
                    ifg_d       = '0;
                    state_d     = S_IFG;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_IFG: begin
                if (ifg_q == I_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    ifg_d = ifg_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A request landing on the cycle the slot frees is taken, not dropped.
        accept = arp_req && (!pending_q || slot_clr);
        if (accept) begin
            pending_d = 1'b1;
            oper_d    = arp_req_oper;
        end else if (slot_clr) begin
            pending_d = 1'b0;
        end
        drop_d = arp_req && !accept;
    end

    assign eth_header_arp_tx_start = (state_q == S_START) && grant_arp_q;
    assign eth_header_ip_tx_start  = (state_q == S_START) && !grant_arp_q;
    assign arp_oper                = oper_q;
    assign busy                    = (state_q != S_IDLE);
    assign arp_drop                = drop_q;
    assign tx_timeout              = timeout_hit;
    assign arp_frame_cnt           = arp_cnt_q;
    assign udp_frame_cnt           = udp_cnt_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: expected start pulses go through a queue checked by a monitor; timing checks are direct.
module tb_eth_tx_sched;

    logic        aclk = 1'b0;
    logic        areset;
    logic        arp_req;
    logic        arp_req_oper;
    logic        udp_frame_ready;
    logic        tx_frame_done;
    logic        arp_start, ip_start, arp_oper, busy, arp_drop, tx_timeout;
    logic [15:0] arp_cnt, udp_cnt;
    logic        w_arp_start, w_ip_start, w_arp_oper, w_busy, w_arp_drop, w_tx_timeout;
    logic [3:0]  w_arp_cnt, w_udp_cnt;

    typedef struct packed {
        logic is_arp;
        logic oper;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   exp_arp = 0;
    int   exp_udp = 0;
    int   s, c0;

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    eth_tx_sched #(.IFG_CYCLES(12), .TIMEOUT(64), .CNT_W(16)) dut (
        .aclk(aclk), .areset(areset), .arp_req(arp_req), .arp_req_oper(arp_req_oper),
        .udp_frame_ready(udp_frame_ready), .tx_frame_done(tx_frame_done),
        .eth_header_arp_tx_start(arp_start), .eth_header_ip_tx_start(ip_start),
        .arp_oper(arp_oper), .busy(busy), .arp_drop(arp_drop), .tx_timeout(tx_timeout),
        .arp_frame_cnt(arp_cnt), .udp_frame_cnt(udp_cnt)
    );

    // Narrow-counter copy on the same stimulus, so counter wrap is reachable in a short run.
    eth_tx_sched #(.IFG_CYCLES(12), .TIMEOUT(64), .CNT_W(4)) u_wrap (
        .aclk(aclk), .areset(areset), .arp_req(arp_req), .arp_req_oper(arp_req_oper),
        .udp_frame_ready(udp_frame_ready), .tx_frame_done(tx_frame_done),
        .eth_header_arp_tx_start(w_arp_start), .eth_header_ip_tx_start(w_ip_start),
        .arp_oper(w_arp_oper), .busy(w_busy), .arp_drop(w_arp_drop), .tx_timeout(w_tx_timeout),
        .arp_frame_cnt(w_arp_cnt), .udp_frame_cnt(w_udp_cnt)
    );

    function automatic exp_t mk(input logic a, input logic o);
        exp_t e;
        e.is_arp = a;
        e.oper   = o;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic sample_at(input int c);
        go_to(c);
        @(negedge aclk);
    endtask

    task automatic wait_start(output int st);
        bit seen;
        int n;
        seen = 1'b0;
        n    = 0;
        st   = cyc;
        while (!seen && n < 300) begin
            @(negedge aclk);
            n++;
            if (arp_start || ip_start) begin
                seen = 1'b1;
                st   = cyc;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL start_wait: no start pulse within 300 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic run_frame(input int len, input bit drop_udp);
        int st;
        wait_start(st);
        tick();
        if (drop_udp) udp_frame_ready = 1'b0;
        go_to(st + len);
        tx_frame_done = 1'b1;
        tick();
        tx_frame_done = 1'b0;
    endtask

    task automatic do_reset();
        areset          = 1'b1;
        arp_req         = 1'b0;
        tx_frame_done   = 1'b0;
        udp_frame_ready = 1'b0;
        repeat (2) tick();
        areset  = 1'b0;
        exp_arp = 0;
        exp_udp = 0;
    endtask

    // Scoreboard monitor: every start pulse must match the oldest expected grant.
    initial begin
        forever begin
            @(negedge aclk);
            if (!areset && (arp_start || ip_start)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL start_unexpected: got arp=%0b ip=%0b with nothing expected (cycle %0d)",
                             arp_start, ip_start, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({arp_start, ip_start, w_arp_start, w_ip_start} !=
                        {mon_e.is_arp, !mon_e.is_arp, mon_e.is_arp, !mon_e.is_arp} ||
                        (mon_e.is_arp && arp_oper != mon_e.oper)) begin
                        errors++;
                        $display("FAIL start_kind: got arp=%0b ip=%0b oper=%0b, expected arp=%0b oper=%0b (cycle %0d)",
                                 arp_start, ip_start, arp_oper, mon_e.is_arp, mon_e.oper, cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        areset = 1'b1; arp_req = 1'b0; arp_req_oper = 1'b0;
        udp_frame_ready = 1'b0; tx_frame_done = 1'b0;
        repeat (3) tick();
        @(negedge aclk);
        chk("rst_outs", 32'({arp_start, ip_start, arp_oper, busy, arp_drop, tx_timeout}), 0);
        chk("rst_cnts", {arp_cnt, udp_cnt}, 0);
        chk("rst_wrap_outs", 32'({w_arp_start, w_ip_start, w_arp_oper, w_busy, w_arp_drop,
                                  w_tx_timeout, w_arp_cnt, w_udp_cnt}), 0);
        tick(); areset = 1'b0; tick();

        // 1: lone ARP reply
        c0 = cyc; arp_req = 1'b1; arp_req_oper = 1'b1; exp_q.push_back(mk(1'b1, 1'b1));
        tick(); arp_req = 1'b0;
        wait_start(s);
        chk("t1_start_latency", s - c0, 2);
        chk("t1_arp_oper", 32'(arp_oper), 1);
        go_to(c0 + 60); tx_frame_done = 1'b1; tick(); tx_frame_done = 1'b0; exp_arp++;
        @(negedge aclk);
        chk("t1_arp_cnt", 32'(arp_cnt), exp_arp);
        sample_at(c0 + 72); chk("t1_busy_in_ifg", 32'(busy), 1);
        sample_at(c0 + 73); chk("t1_busy_after_ifg", 32'(busy), 0);

        // 2: alternation with both sides pending, starting from last_grant=UDP
        do_reset(); tick();
        arp_req = 1'b1; arp_req_oper = 1'b0;
        exp_q.push_back(mk(1'b1, 1'b0)); exp_q.push_back(mk(1'b0, 1'b0));
        tick(); arp_req = 1'b0; udp_frame_ready = 1'b1;
        run_frame(5, 1'b0); exp_arp++;
        wait_start(s); tick();
        arp_req = 1'b1; arp_req_oper = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b1)); exp_q.push_back(mk(1'b0, 1'b0));
        tick(); arp_req = 1'b0;
        go_to(s + 8); tx_frame_done = 1'b1; tick(); tx_frame_done = 1'b0; exp_udp++;
        run_frame(4, 1'b0); exp_arp++;
        run_frame(3, 1'b1); exp_udp++;
        @(negedge aclk);
        chk("t2_arp_cnt", 32'(arp_cnt), exp_arp);
        chk("t2_udp_cnt", 32'(udp_cnt), exp_udp);

        // 3: slot full drops, release-cycle request accepted
        go_to(cyc + 14);
        c0 = cyc; arp_req = 1'b1; arp_req_oper = 1'b0; exp_q.push_back(mk(1'b1, 1'b0));
        tick(); arp_req = 1'b0;
        go_to(c0 + 5); arp_req = 1'b1; arp_req_oper = 1'b1;
        tick(); arp_req = 1'b0;
        @(negedge aclk); chk("t3_drop_pulse", 32'(arp_drop), 1);
        tick(); @(negedge aclk);
        chk("t3_drop_one_cycle", 32'(arp_drop), 0);
        chk("t3_oper_kept", 32'(arp_oper), 0);
        go_to(c0 + 10);
        tx_frame_done = 1'b1; arp_req = 1'b1; arp_req_oper = 1'b1; exp_q.push_back(mk(1'b1, 1'b1));
        tick(); tx_frame_done = 1'b0; arp_req = 1'b0; exp_arp++;
        @(negedge aclk);
        chk("t3_no_drop_on_release", 32'(arp_drop), 0);
        chk("t3_arp_cnt_a", 32'(arp_cnt), exp_arp);
        run_frame(3, 1'b0); exp_arp++;
        @(negedge aclk); chk("t3_arp_cnt_b", 32'(arp_cnt), exp_arp);

        // 4: watchdog on a UDP frame and on an ARP frame
        go_to(cyc + 14);
        udp_frame_ready = 1'b1; exp_q.push_back(mk(1'b0, 1'b0));
        wait_start(s); tick(); udp_frame_ready = 1'b0;
        sample_at(s + 63); chk("t4_no_early_timeout", 32'(tx_timeout), 0);
        sample_at(s + 64); chk("t4_timeout_pulse", 32'(tx_timeout), 1);
        sample_at(s + 65); chk("t4_timeout_one_cycle", 32'(tx_timeout), 0);
        chk("t4_udp_cnt_unchanged", 32'(udp_cnt), exp_udp);
        go_to(s + 70); tx_frame_done = 1'b1; tick(); tx_frame_done = 1'b0;
        sample_at(s + 76); chk("t4_busy_in_ifg", 32'(busy), 1);
        sample_at(s + 77); chk("t4_idle_after_ifg", 32'(busy), 0);
        chk("t4_done_in_ifg_ignored", 32'(udp_cnt), exp_udp);
        tick(); arp_req = 1'b1; arp_req_oper = 1'b0; exp_q.push_back(mk(1'b1, 1'b0));
        tick(); arp_req = 1'b0;
        wait_start(s);
        sample_at(s + 64); chk("t4_arp_timeout_pulse", 32'(tx_timeout), 1);
        sample_at(s + 85); chk("t4_arp_slot_cleared", 32'(busy), 0);
        chk("t4_arp_cnt_unchanged", 32'(arp_cnt), exp_arp);

        // 5: counter wrap on the narrow instance
        udp_frame_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(mk(1'b0, 1'b0));
            run_frame(2, i == 13);
            exp_udp++;
            if (i == 12) begin
                @(negedge aclk);
                chk("t5_pre_wrap", 32'(w_udp_cnt), 15);
            end
        end
        @(negedge aclk);
        chk("t5_wrap_to_zero", 32'(w_udp_cnt), exp_udp % 16);
        chk("t5_wide_cnt", 32'(udp_cnt), exp_udp);

        // 6: reset in the middle of a frame with an ARP queued
        go_to(cyc + 14);
        udp_frame_ready = 1'b1; exp_q.push_back(mk(1'b0, 1'b0));
        wait_start(s); tick();
        udp_frame_ready = 1'b0; arp_req = 1'b1; arp_req_oper = 1'b1;
        tick(); arp_req = 1'b0;
        go_to(s + 3); areset = 1'b1; tick(); areset = 1'b0; exp_arp = 0; exp_udp = 0;
        @(negedge aclk);
        chk("t6_outs_cleared", 32'({arp_start, ip_start, arp_oper, busy, arp_drop, tx_timeout}), 0);
        chk("t6_cnts_cleared", {arp_cnt, udp_cnt}, 0);
        go_to(s + 6); tx_frame_done = 1'b1; tick(); tx_frame_done = 1'b0;
        @(negedge aclk);
        chk("t6_done_ignored", {arp_cnt, udp_cnt}, 0);
        sample_at(s + 12); chk("t6_slot_empty", 32'(busy), 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
